// File: rtl/axi_sram_slave_pkg.sv
// Shared definitions for the AXI SRAM responder: burst types, response codes, FSM states.
package axi_sram_slave_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } axi_burst_e;

  localparam logic [1:0] RespOkay = 2'b00;

  typedef enum logic [4:0] {
    StIdle    = 5'b00001,
    StRdWait  = 5'b00010,
    StRdBurst = 5'b00100,
    StWrData  = 5'b01000,
    StWrResp  = 5'b10000
  } slave_state_e;

  // WRAP is served as a plain increment; only FIXED holds the word index.
  function automatic logic burst_advances(input logic [1:0] burst);
    return burst != BurstFixed;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between a cache master and the SRAM responder.
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sram_slave_mem.sv
// Word array: synchronous byte-strobed write, asynchronous read. Contents are never reset.
module axi_sram_slave_mem #(
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_wstrb,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [2**ADDR_BITS];

  // Byte lanes are written only where the strobe is set.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < 4; k++) begin
        if (i_wstrb[k]) r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 SRAM responder: one transaction at a time, INCR/FIXED bursts up to 16 beats,
// strobed writes, programmable read latency.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned RD_DELAY  = 2
) (
  input  logic            aclk,
  input  logic            aresetn,
  axi_sram_slave_if.slave s_axi
);

  localparam int unsigned        CntBits    = (RD_DELAY > 1) ? $clog2(RD_DELAY + 1) : 1;
  localparam logic [CntBits-1:0] RdDelayCnt = CntBits'(RD_DELAY);

  slave_state_e         r_state;
  logic [3:0]           r_rid;
  logic [3:0]           r_bid;
  logic [3:0]           r_len;
  logic [3:0]           r_beat;
  logic [1:0]           r_burst;
  logic [ADDR_BITS-1:0] r_idx;
  logic [CntBits-1:0]   r_cnt;
  logic [31:0]          r_rdata;
  logic                 r_rvalid;
  logic                 r_rlast;
  logic                 r_bvalid;

  logic                 w_arready;
  logic                 w_awready;
  logic                 w_wready;
  logic                 w_ar_hs;
  logic                 w_aw_hs;
  logic                 w_r_hs;
  logic                 w_w_hs;
  logic [ADDR_BITS-1:0] w_ar_idx;
  logic [ADDR_BITS-1:0] w_aw_idx;
  logic [ADDR_BITS-1:0] w_next_idx;
  logic [ADDR_BITS-1:0] w_rd_idx;
  logic [31:0]          w_mem_rdata;
  logic                 w_unused;

  // Address channels are open only in IDLE; reads take priority over a pending write.
  assign w_arready = (r_state == StIdle) && aresetn;
  assign w_awready = w_arready && !s_axi.arvalid;
  assign w_wready  = (r_state == StWrData);

  assign w_ar_hs = s_axi.arvalid && w_arready;
  assign w_aw_hs = s_axi.awvalid && w_awready;
  assign w_r_hs  = r_rvalid && s_axi.rready;
  assign w_w_hs  = s_axi.wvalid && w_wready;

  // Byte address to word index; upper bits are dropped so the index wraps.
  assign w_ar_idx   = s_axi.araddr[ADDR_BITS+1:2];
  assign w_aw_idx   = s_axi.awaddr[ADDR_BITS+1:2];
  assign w_next_idx = burst_advances(r_burst) ? r_idx + ADDR_BITS'(1) : r_idx;

  // Read port points at whatever word rdata must hold after the coming edge.
  always_comb begin
    w_rd_idx = r_idx;
    if (r_state == StIdle) begin
      w_rd_idx = w_ar_idx;
    end else if (r_state == StRdBurst) begin
      w_rd_idx = w_next_idx;
    end
  end

  axi_sram_slave_mem #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .i_clk   (aclk),
    .i_we    (w_w_hs),
    .i_waddr (r_idx),
    .i_wdata (s_axi.wdata),
    .i_wstrb (s_axi.wstrb),
    .i_raddr (w_rd_idx),
    .o_rdata (w_mem_rdata)
  );

  // Transaction FSM with registered R/B channel outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= StIdle;
      r_rid    <= '0;
      r_bid    <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_burst  <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_bvalid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_ar_hs) begin
            r_rid   <= s_axi.arid;
            r_idx   <= w_ar_idx;
            r_len   <= s_axi.arlen;
            r_burst <= s_axi.arburst;
            r_beat  <= '0;
            r_cnt   <= '0;
            if (RD_DELAY == 0) begin
              r_rdata  <= w_mem_rdata;
              r_rvalid <= 1'b1;
              r_rlast  <= (s_axi.arlen == 4'd0);
              r_state  <= StRdBurst;
            end else begin
              r_state <= StRdWait;
            end
          end else if (w_aw_hs) begin
            r_bid   <= s_axi.awid;
            r_idx   <= w_aw_idx;
            r_len   <= s_axi.awlen;
            r_burst <= s_axi.awburst;
            r_beat  <= '0;
            r_state <= StWrData;
          end
        end
        StRdWait: begin
          if (r_cnt == RdDelayCnt) begin
            r_cnt    <= '0;
            r_rdata  <= w_mem_rdata;
            r_rvalid <= 1'b1;
            r_rlast  <= (r_len == 4'd0);
            r_state  <= StRdBurst;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StRdBurst: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= StIdle;
            end else begin
              r_beat  <= r_beat + 4'd1;
              r_idx   <= w_next_idx;
              r_rdata <= w_mem_rdata;
              r_rlast <= ((r_beat + 4'd1) == r_len);
            end
          end
        end
        StWrData: begin
          // Only wlast ends the burst; the beat count is informational.
          if (w_w_hs) begin
            r_beat <= r_beat + 4'd1;
            r_idx  <= w_next_idx;
            if (s_axi.wlast) begin
              r_bvalid <= 1'b1;
              r_state  <= StWrResp;
            end
          end
        end
        StWrResp: begin
          if (s_axi.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s_axi.arready = w_arready;
  assign s_axi.awready = w_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.rid     = r_rid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = RespOkay;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.bid     = r_bid;
  assign s_axi.bresp   = RespOkay;
  assign s_axi.bvalid  = r_bvalid;

  // Sideband fields the responder deliberately ignores.
  assign w_unused = ^{s_axi.arsize, s_axi.arlock, s_axi.arcache, s_axi.arprot,
                      s_axi.awsize, s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.wid,
                      s_axi.araddr[31:ADDR_BITS+2], s_axi.araddr[1:0],
                      s_axi.awaddr[31:ADDR_BITS+2], s_axi.awaddr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a word-array reference model and expected-beat queues.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  localparam int unsigned AddrBits = 16;
  localparam int unsigned RdDelay  = 2;
  localparam int          Budget   = 200;

  logic aclk;
  logic aresetn;
  int   checks   = 0;
  int   failures = 0;

  axi_sram_slave_if u_if ();

  axi_sram_slave #(
    .ADDR_BITS(AddrBits),
    .RD_DELAY (RdDelay)
  ) u_dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .s_axi  (u_if)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } rbeat_t;

  logic [31:0] model [int];
  rbeat_t      exp_r[$];
  logic [3:0]  exp_b[$];
  logic [31:0] got_r[$];
  logic [31:0] wq_data [16];
  logic [3:0]  wq_strb [16];
  bit          rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mget(input int idx);
    if (model.exists(idx)) return model[idx];
    return 32'h0;
  endfunction

  function automatic logic [31:0] got(input int i);
    if (got_r.size() > i) return got_r[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic ready_of(input int ch);
    case (ch)
      0:       return u_if.arready;
      1:       return u_if.awready;
      2:       return u_if.wready;
      default: return u_if.bvalid;
    endcase
  endfunction

  // Per-cycle comparison of R and B channels against the expected queues.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      if (u_if.rvalid) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected_beat", 32'(u_if.rvalid), 32'd0);
        end else begin
          check("rdata", u_if.rdata, exp_r[0].data);
          check("rid", 32'(u_if.rid), 32'(exp_r[0].id));
          check("rlast", 32'(u_if.rlast), 32'(exp_r[0].last));
          check("rresp", 32'(u_if.rresp), 32'd0);
          if (u_if.rready) begin
            got_r.push_back(u_if.rdata);
            void'(exp_r.pop_front());
          end
        end
      end
      if (u_if.bvalid) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", 32'(u_if.bvalid), 32'd0);
        end else begin
          check("bid", 32'(u_if.bid), 32'(exp_b[0]));
          check("bresp", 32'(u_if.bresp), 32'd0);
          if (u_if.bready) void'(exp_b.pop_front());
        end
      end
    end
  end

  // Waits (bounded) for a ready/valid condition, then steps past the handshake edge.
  task automatic wait_hs(input int ch, input string name);
    int n = 0;
    @(negedge aclk);
    while (!ready_of(ch) && n < Budget) begin
      @(negedge aclk);
      n++;
    end
    if (ch == 0 && u_if.awvalid) check("awready_vs_arvalid", 32'(u_if.awready), 32'd0);
    checks++;
    if (!ready_of(ch)) begin
      failures++;
      $display("FAIL %s_timeout: no handshake in %0d cycles, required one", name, Budget);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst);
    int idx = int'(addr[AddrBits+1:2]);
    for (int i = 0; i <= int'(len); i++) begin
      exp_r.push_back('{data: mget(idx), id: id, last: (i == int'(len))});
      if (burst != BurstFixed) idx = (idx + 1) % (1 << AddrBits);
    end
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input int pat, output int lat);
    int cyc = 0;
    push_read(id, addr, len, burst);
    got_r.delete();
    u_if.arid    = id;
    u_if.araddr  = addr;
    u_if.arlen   = len;
    u_if.arburst = burst;
    u_if.arvalid = 1'b1;
    wait_hs(0, "ar");
    u_if.arvalid = 1'b0;
    lat = -1;
    while (exp_r.size() > 0 && cyc < Budget) begin
      u_if.rready = (pat == 0) ? 1'b1 : rpat[cyc % 4];
      @(negedge aclk);
      if (u_if.rvalid && lat < 0) lat = cyc;
      if (u_if.awvalid) check("awready_during_read", 32'(u_if.awready), 32'd0);
      @(posedge aclk);
      #1;
      cyc++;
    end
    check("r_beats_outstanding", 32'(exp_r.size()), 32'd0);
    exp_r.delete();
    u_if.rready = 1'b0;
    check("rd_latency", 32'(lat), 32'((RdDelay > 0) ? RdDelay + 1 : 1));
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int nbeats, input int bdelay);
    int idx = int'(addr[AddrBits+1:2]);
    u_if.awid    = id;
    u_if.awaddr  = addr;
    u_if.awlen   = len;
    u_if.awburst = burst;
    u_if.awvalid = 1'b1;
    wait_hs(1, "aw");
    u_if.awvalid = 1'b0;
    exp_b.push_back(id);
    for (int i = 0; i < nbeats; i++) begin
      logic [31:0] m;
      u_if.wdata  = wq_data[i];
      u_if.wstrb  = wq_strb[i];
      u_if.wlast  = (i == nbeats - 1);
      u_if.wvalid = 1'b1;
      wait_hs(2, "w");
      m = mget(idx);
      for (int k = 0; k < 4; k++) if (wq_strb[i][k]) m[8*k +: 8] = wq_data[i][8*k +: 8];
      model[idx] = m;
      if (burst != BurstFixed) idx = (idx + 1) % (1 << AddrBits);
    end
    u_if.wvalid = 1'b0;
    u_if.wlast  = 1'b0;
    for (int d = 0; d < bdelay; d++) begin
      @(negedge aclk);
      check("bvalid_held", 32'(u_if.bvalid), 32'd1);
      @(posedge aclk);
      #1;
    end
    u_if.bready = 1'b1;
    wait_hs(3, "b");
    u_if.bready = 1'b0;
    check("b_consumed", 32'(exp_b.size()), 32'd0);
    exp_b.delete();
  endtask

  task automatic write1(input logic [31:0] addr, input logic [31:0] data);
    wq_data[0] = data;
    wq_strb[0] = 4'hF;
    axi_write(4'd0, addr, 4'd0, BurstIncr, 1, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    aresetn = 1'b0;
    u_if.arid = '0; u_if.araddr = '0; u_if.arlen = '0; u_if.arsize = 3'd2; u_if.arburst = '0;
    u_if.arlock = '0; u_if.arcache = '0; u_if.arprot = '0; u_if.arvalid = 1'b0;
    u_if.rready = 1'b0;
    u_if.awid = '0; u_if.awaddr = '0; u_if.awlen = '0; u_if.awsize = 3'd2; u_if.awburst = '0;
    u_if.awlock = '0; u_if.awcache = '0; u_if.awprot = '0; u_if.awvalid = 1'b0;
    u_if.wid = '0; u_if.wdata = '0; u_if.wstrb = '0; u_if.wlast = 1'b0; u_if.wvalid = 1'b0;
    u_if.bready = 1'b0;

    // Reset values.
    #12;
    check("rst_arready", 32'(u_if.arready), 32'd0);
    check("rst_awready", 32'(u_if.awready), 32'd0);
    check("rst_wready", 32'(u_if.wready), 32'd0);
    check("rst_rvalid", 32'(u_if.rvalid), 32'd0);
    check("rst_rlast", 32'(u_if.rlast), 32'd0);
    check("rst_bvalid", 32'(u_if.bvalid), 32'd0);
    check("rst_rdata", u_if.rdata, 32'd0);
    check("rst_rid", 32'(u_if.rid), 32'd0);
    check("rst_bid", 32'(u_if.bid), 32'd0);
    #10 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Preload through the write channel.
    write1(32'h40, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      wq_data[i] = 32'hA000_0000 + 32'(i);
      wq_strb[i] = 4'hF;
    end
    axi_write(4'd1, 32'h100, 4'd7, BurstIncr, 8, 0);
    for (int i = 0; i < 4; i++) begin
      wq_data[i] = 32'hB000_0000 + 32'(i);
      wq_strb[i] = 4'hF;
    end
    axi_write(4'd2, 32'h300, 4'd3, BurstIncr, 4, 1);
    write1(32'h200, 32'hDEAD_BEEF);

    // Single read with RD_DELAY = 2.
    axi_read(4'd3, 32'h40, 4'd0, BurstIncr, 0, lat);
    check("single_latency_lit", 32'(lat), 32'd3);
    check("single_data_lit", got(0), 32'h1234_5678);

    // 8-beat INCR fill, then arready must be back.
    axi_read(4'd5, 32'h100, 4'd7, BurstIncr, 0, lat);
    check("fill_beats", 32'(got_r.size()), 32'd8);
    check("fill_last_lit", got(7), 32'hA000_0007);
    @(negedge aclk);
    check("arready_after_burst", 32'(u_if.arready), 32'd1);
    @(posedge aclk);
    #1;

    // rready backpressure 1-0-0-1.
    axi_read(4'd6, 32'h300, 4'd3, BurstIncr, 1, lat);
    check("bp_beats", 32'(got_r.size()), 32'd4);
    check("bp_beat2_lit", got(2), 32'hB000_0002);

    // FIXED burst repeats the same word.
    axi_read(4'd7, 32'h40, 4'd2, BurstFixed, 0, lat);
    check("fixed_beat2_lit", got(2), 32'h1234_5678);

    // Strobed write, response held for three cycles.
    wq_data[0] = 32'hAABB_CCDD; wq_strb[0] = 4'b0011;
    wq_data[1] = 32'h1122_3344; wq_strb[1] = 4'hF;
    axi_write(4'd9, 32'h200, 4'd1, BurstIncr, 2, 3);
    axi_read(4'd9, 32'h200, 4'd1, BurstIncr, 0, lat);
    check("strb_word0_lit", got(0), 32'hDEAD_CCDD);
    check("strb_word1_lit", got(1), 32'h1122_3344);

    // Zero strobe writes nothing.
    wq_data[0] = 32'hFFFF_FFFF; wq_strb[0] = 4'h0;
    axi_write(4'd4, 32'h40, 4'd0, BurstIncr, 1, 0);
    axi_read(4'd4, 32'h40, 4'd0, BurstIncr, 0, lat);
    check("zero_strb_lit", got(0), 32'h1234_5678);

    // Late wlast: awlen says one beat, two are sent.
    wq_data[0] = 32'h5A5A_0001; wq_strb[0] = 4'hF;
    wq_data[1] = 32'h5A5A_0002; wq_strb[1] = 4'hF;
    axi_write(4'd8, 32'h500, 4'd0, BurstIncr, 2, 0);
    axi_read(4'd8, 32'h500, 4'd1, BurstIncr, 0, lat);
    check("late_wlast_lit", got(1), 32'h5A5A_0002);

    // Index wrap and ignored upper address bits.
    wq_data[0] = 32'h0F0F_0001; wq_strb[0] = 4'hF;
    wq_data[1] = 32'h0F0F_0002; wq_strb[1] = 4'hF;
    axi_write(4'd10, 32'h0003_FFFC, 4'd1, BurstIncr, 2, 0);
    axi_read(4'd11, 32'hFFFF_FFFC, 4'd1, BurstIncr, 0, lat);
    check("wrap_beat0_lit", got(0), 32'h0F0F_0001);
    check("wrap_beat1_lit", got(1), 32'h0F0F_0002);

    // W presented before AW is stalled.
    u_if.wdata  = 32'h7777_7777;
    u_if.wstrb  = 4'hF;
    u_if.wvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      check("wready_before_aw", 32'(u_if.wready), 32'd0);
      check("awready_idle", 32'(u_if.awready), 32'd1);
      @(posedge aclk);
      #1;
    end
    u_if.wvalid = 1'b0;

    // Simultaneous AR and AW: read first, then the write, then read-back.
    u_if.awid    = 4'd2;
    u_if.awaddr  = 32'h100;
    u_if.awlen   = 4'd0;
    u_if.awburst = BurstIncr;
    u_if.awvalid = 1'b1;
    axi_read(4'd1, 32'h100, 4'd1, BurstIncr, 0, lat);
    check("collide_read_lit", got(0), 32'hA000_0000);
    wq_data[0] = 32'hCAFE_F00D; wq_strb[0] = 4'hF;
    axi_write(4'd2, 32'h100, 4'd0, BurstIncr, 1, 0);
    axi_read(4'd1, 32'h100, 4'd0, BurstIncr, 0, lat);
    check("collide_readback_lit", got(0), 32'hCAFE_F00D);

    // Reset in the middle of an 8-beat read.
    push_read(4'd12, 32'h100, 4'd7, BurstIncr);
    u_if.arid = 4'd12; u_if.araddr = 32'h100; u_if.arlen = 4'd7; u_if.arburst = BurstIncr;
    u_if.arvalid = 1'b1;
    wait_hs(0, "ar_rst");
    u_if.arvalid = 1'b0;
    u_if.rready  = 1'b1;
    n = 0;
    while (exp_r.size() > 5 && n < Budget) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("rst_mid_progress", 32'(exp_r.size()), 32'd5);
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_rvalid", 32'(u_if.rvalid), 32'd0);
    check("rst_mid_rlast", 32'(u_if.rlast), 32'd0);
    check("rst_mid_rdata", u_if.rdata, 32'd0);
    check("rst_mid_arready", 32'(u_if.arready), 32'd0);
    exp_r.delete();
    u_if.rready = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_rel_arready", 32'(u_if.arready), 32'd1);
    check("rst_rel_rvalid", 32'(u_if.rvalid), 32'd0);
    @(posedge aclk);
    #1;
    axi_read(4'd13, 32'h40, 4'd0, BurstIncr, 0, lat);
    check("after_rst_read_lit", got(0), 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
